// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch sequencer with static JAL redirect feeding an 8-deep instruction/PC queue.
module inst_fetch_queue #(
   parameter int          QUEUE_ADDR_W = 3,
   parameter logic [31:0] RESET_PC     = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic        icache_req_valid,
   output logic [31:0] icache_req_addr,
   input  logic        icache_resp_valid,
   input  logic [31:0] icache_resp_inst,
   output logic        issue_valid,
   output logic [31:0] issue_inst,
   output logic [31:0] issue_pc,
   input  logic        issue_ready,
   input  logic        flush_in,
   input  logic [31:0] flush_pc
);
   localparam int DEPTH = 1 << QUEUE_ADDR_W;
   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
   state_t state, state_nx;
   logic [31:0] pc, pc_nx, jal_imm;
   logic [QUEUE_ADDR_W-1:0] head, tail;
   logic [QUEUE_ADDR_W:0] count;
   logic [31:0] q_inst [DEPTH];
   logic [31:0] q_pc [DEPTH];
   logic full, push, pop;
   assign full = count[QUEUE_ADDR_W];
   assign jal_imm = {{11{icache_resp_inst[31]}}, icache_resp_inst[31], icache_resp_inst[19:12],
                     icache_resp_inst[20], icache_resp_inst[30:21], 1'b0};
   assign pc_nx = (icache_resp_inst[6:0] == 7'b1101111) ? pc + jal_imm : pc + 32'd4;
   assign push = !flush_in && state == WAIT && icache_resp_valid;
   assign pop = !flush_in && count != 0 && issue_ready;
   assign icache_req_valid = state == WAIT;
   assign icache_req_addr = pc;
   assign issue_valid = count != 0;
   assign issue_inst = q_inst[head];
   assign issue_pc = q_pc[head];
   // a response always retires the single outstanding request, even under flush
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: state_nx = (!full && !flush_in) ? WAIT : IDLE;
         WAIT: state_nx = icache_resp_valid ? IDLE : (flush_in ? DROP : WAIT);
         DROP: state_nx = icache_resp_valid ? IDLE : DROP;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= IDLE;
         pc <= RESET_PC;
         head <= '0;
         tail <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_inst[i] <= '0;
            q_pc[i] <= '0;
         end
      end else if (rdy_in) begin
         state <= state_nx;
         if (flush_in) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            pc <= flush_pc;
         end else begin
            if (push) begin
               q_inst[tail] <= icache_resp_inst;
               q_pc[tail] <= pc;
               tail <= tail + 1'b1;
               pc <= pc_nx;
            end
            if (pop) head <= head + 1'b1;
            count <= count + (QUEUE_ADDR_W+1)'(push) - (QUEUE_ADDR_W+1)'(pop);
         end
      end
   end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: random icache/issue/flush/stall traffic against a queue-based reference model.
module tb_inst_fetch_queue;
   logic clk_in = 0, rst_in = 1, rdy_in = 1;
   logic icache_req_valid, icache_resp_valid = 0, issue_valid, issue_ready = 0, flush_in = 0;
   logic [31:0] icache_req_addr, icache_resp_inst = 0, issue_inst, issue_pc, flush_pc = 0;

   inst_fetch_queue dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
      .icache_resp_valid(icache_resp_valid), .icache_resp_inst(icache_resp_inst),
      .issue_valid(issue_valid), .issue_inst(issue_inst), .issue_pc(issue_pc),
      .issue_ready(issue_ready), .flush_in(flush_in), .flush_pc(flush_pc)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0, failures = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] a);
      logic [31:0] h;
      if (a == 32'h10) return 32'h0100006F;
      if (a < 32'h10) return 32'h00000013;
      h = (a ^ 32'h5bd1e995) * 32'h9E3779B1;
      h = h ^ (h >> 15);
      return (h[3:0] == 4'd0) ? {h[31:7], 7'h6F} : {h[31:7], 7'h13};
   endfunction

   function automatic logic [31:0] next_pc(input logic [31:0] p, input logic [31:0] w);
      int off;
      if (w[6:0] != 7'h6F) return p + 32'd4;
      off = w[31] ? -1048576 : 0;
      off += int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      return p + 32'(off);
   endfunction

   typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
   ent_t q[$];
   logic [31:0] mpc = 0, req_a = 0, fpc_v = 0, w_v;
   bit pending = 0, dropped = 0, rdy_v, flush_v, ready_v, resp_v, seen20 = 0;
   int lat = 0, pushes = 0;

   initial begin
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check("rst_req_valid", icache_req_valid, 0);
      check("rst_req_addr", icache_req_addr, 32'h0);
      check("rst_issue_valid", issue_valid, 0);
      check("rst_issue_inst", issue_inst, 32'h0);
      check("rst_issue_pc", issue_pc, 32'h0);
      rst_in = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk_in);
         check("issue_valid", issue_valid, q.size() != 0);
         if (q.size() != 0) begin
            check("issue_pc", issue_pc, q[0].pc);
            check("issue_inst", issue_inst, q[0].inst);
         end
         if (dropped) check("req_in_drop", icache_req_valid, 0);
         if (icache_req_valid) check("req_addr", icache_req_addr, mpc);
         if (icache_req_valid && !pending) begin
            check("req_not_full", q.size() < 8, 1);
            if (icache_req_addr == 32'h20 && c < 150) seen20 = 1;
            pending = 1;
            req_a = icache_req_addr;
            lat = $urandom_range(0, 3);
         end
         if (c == 299) check("full_no_req", icache_req_valid, 0);
         if (c < 200) begin
            rdy_v = !(c >= 150 && c < 155);
            flush_v = 0;
            ready_v = 1;
         end else if (c < 300) begin
            rdy_v = 1;
            flush_v = 0;
            ready_v = 0;
         end else if (c < 1800) begin
            rdy_v = $urandom_range(0, 9) != 0;
            flush_v = $urandom_range(0, 19) == 0;
            ready_v = $urandom_range(0, 9) < 6;
         end else begin
            rdy_v = $urandom_range(0, 9) < 7;
            flush_v = $urandom_range(0, 29) == 0;
            ready_v = $urandom_range(0, 9) < 3;
         end
         fpc_v = $urandom_range(0, 1) ? 32'h100 : ($urandom & ~32'h3);
         resp_v = 0;
         if (rdy_v && pending) begin
            if (lat == 0) begin
               resp_v = 1;
               pending = 0;
            end else lat--;
         end
         w_v = word_of(req_a);
         rdy_in = rdy_v;
         flush_in = flush_v;
         flush_pc = fpc_v;
         issue_ready = ready_v;
         icache_resp_valid = resp_v;
         icache_resp_inst = resp_v ? w_v : $urandom;
         @(posedge clk_in);
         if (rdy_v) begin
            if (flush_v) begin
               if (resp_v) dropped = 0;
               else if (pending) dropped = 1;
               q.delete();
               mpc = fpc_v;
            end else begin
               if (ready_v && q.size() != 0) void'(q.pop_front());
               if (resp_v) begin
                  if (dropped) dropped = 0;
                  else begin
                     q.push_back('{mpc, w_v});
                     mpc = next_pc(mpc, w_v);
                     pushes++;
                  end
               end
            end
         end
      end
      check("jal_redirect_0x20", seen20, 1);
      check("progress", pushes > 100, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
